// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts
// one byte plus odd parity and stop on device clock falls and checks the device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 1200,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       clk_oe,
   output logic       dat_oe
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t            state_q, state_d;
   logic [INH_W-1:0]  inh_q, inh_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [3:0]        bit_q, bit_d;
   logic [9:0]        frame_q, frame_d;
   logic              clk_oe_d, dat_oe_d, done_d, err_d, ready_d;

   logic clk_meta, clk_sync, clk_prev;
   logic dat_meta, dat_sync;
   logic fall;

   // Two-flop synchronisers; idle-high reset values avoid a false fall after reset
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_dat_in;
         dat_sync <= dat_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         inh_q    <= '0;
         to_q     <= '0;
         bit_q    <= '0;
         frame_q  <= '0;
         clk_oe   <= 1'b0;
         dat_oe   <= 1'b0;
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         inh_q    <= inh_d;
         to_q     <= to_d;
         bit_q    <= bit_d;
         frame_q  <= frame_d;
         clk_oe   <= clk_oe_d;
         dat_oe   <= dat_oe_d;
         tx_done  <= done_d;
         tx_error <= err_d;
         tx_ready <= ready_d;
         busy     <= ~ready_d;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_d  = state_q;
      inh_d    = inh_q;
      to_d     = to_q;
      bit_d    = bit_q;
      frame_d  = frame_q;
      clk_oe_d = 1'b0;
      dat_oe_d = dat_oe;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            dat_oe_d = 1'b0;
            if (tx_valid && tx_ready) begin
               frame_d  = {1'b1, ~^tx_data, tx_data};
               bit_d    = '0;
               inh_d    = '0;
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_q == INH_LAST) begin
               to_d     = '0;
               dat_oe_d = 1'b1;
               state_d  = S_REQ;
            end else begin
               clk_oe_d = 1'b1;
               inh_d    = inh_q + INH_W'(1);
               // start bit goes on the line during the final inhibit cycle
               if (inh_q == INH_PRE) dat_oe_d = 1'b1;
            end
         end
         S_REQ: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (fall) begin
               dat_oe_d = ~frame_q[0];
               frame_d  = {1'b0, frame_q[9:1]};
               bit_d    = bit_q + 4'd1;
               if (bit_q == 4'd9) state_d = S_ACK;
            end
         end
         S_ACK: begin
            dat_oe_d = 1'b0;
            if (fall) begin
               if (!dat_sync) begin
                  state_d = S_WAIT_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            dat_oe_d = 1'b0;
            if (clk_sync && dat_sync) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      // Timeout overrides any event seen in the same cycle
      if (state_q inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE}) begin
         if (to_q == TO_LAST) begin
            state_d  = S_IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
         end else begin
            to_d = to_q + TO_W'(1);
         end
      end

      // Ready only once IDLE has been held for a full cycle, i.e. after the result pulse
      ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a wired-AND PS/2 device model clocks frames
// out of the host, captures the line, and drives or withholds the ACK.
module tb_ps2_host_tx;

   localparam int INHIBIT = 1200;
   localparam int TIMEOUT = 5000;
   localparam int HALF    = 20;

   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, tx_done, tx_error;
   logic       ps2_clk_in, ps2_dat_in;
   logic       clk_oe, dat_oe;
   logic       dev_clk, dev_dat;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // Open-drain bus: low if either side pulls
   assign ps2_clk_in = dev_clk & ~clk_oe;
   assign ps2_dat_in = dev_dat & ~dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .clk_oe     (clk_oe),
      .dat_oe     (dat_oe)
   );

   // Monitor: pulse counts, readiness after a pulse, inhibit window shape
   int   done_cnt = 0, err_cnt = 0, busy_bad = 0;
   int   inh_run = 0, inh_dat = 0, inh_len = 0, inh_dat_len = 0;
   logic inh_last_run = 1'b0, inh_last_dat = 1'b0;
   logic pulse_prev = 1'b0, ready_after = 1'b0;

   always @(negedge clock) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (pulse_prev) ready_after = tx_ready;
      pulse_prev = tx_done | tx_error;
      if (resetn && (busy == tx_ready)) busy_bad++;
      if (clk_oe) begin
         inh_run++;
         if (dat_oe) inh_dat++;
         inh_last_run = dat_oe;
      end else if (inh_run != 0) begin
         inh_len      = inh_run;
         inh_dat_len  = inh_dat;
         inh_last_dat = inh_last_run;
         inh_run      = 0;
         inh_dat      = 0;
      end
   end

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       ack;
      logic       done;
      logic       err;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      ok = tx_ready;
   endtask

   // Waits through the inhibit window until the host releases the clock (REQ)
   task automatic wait_req(output bit ok);
      int n;
      ok = 1'b1;
      n  = 0;
      while (!clk_oe && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!clk_oe) ok = 1'b0;
      n = 0;
      while (clk_oe && n < INHIBIT + 100) begin
         @(negedge clock);
         n++;
      end
      if (clk_oe) ok = 1'b0;
   endtask

   // Device side: 11 clock pulses, line sampled late in each low phase
   task automatic dev_frame(input logic ack, input bit drop, output logic [10:0] bits, output bit ok);
      bits = '0;
      wait_req(ok);
      if (drop) tx_valid = 1'b0;
      if (ok) begin
         repeat (5) @(negedge clock);
         bits[0] = ps2_dat_in;
         for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_dat = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            if (i < 10) bits[i+1] = ps2_dat_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clock);
         end
         dev_dat = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          d0, e0;
      logic [10:0] bits;
      bit          ok;
      wait_ready(ok);
      chk($sformatf("v%0d_ready_before", idx), 32'(ok), 32'd1);
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data  = v.data;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      dev_frame(v.ack, 1'b0, bits, ok);
      chk($sformatf("v%0d_handshake", idx), 32'(ok), 32'd1);
      wait_ready(ok);
      chk($sformatf("v%0d_ready_after", idx), 32'(ok), 32'd1);
      @(negedge clock);
      chk($sformatf("v%0d_frame", idx), 32'(bits), 32'({1'b1, v.par, v.data, 1'b0}));
      chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - d0), 32'(v.done));
      chk($sformatf("v%0d_err_pulses", idx), 32'(err_cnt - e0), 32'(v.err));
      chk($sformatf("v%0d_ready_next", idx), 32'(ready_after), 32'd1);
      chk($sformatf("v%0d_inhibit_len", idx), 32'(inh_len), 32'(INHIBIT));
      chk($sformatf("v%0d_inhibit_dat_cycles", idx), 32'(inh_dat_len), 32'd1);
      chk($sformatf("v%0d_inhibit_last_dat", idx), 32'(inh_last_dat), 32'd1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d0, e0, n;
      logic [10:0] bits;
      bit          ok;

      //           data   par   ack   done  err
      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'hF4, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1};

      resetn   = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clk_oe", 32'(clk_oe), 32'd0);
      chk("rst_dat_oe", 32'(dat_oe), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_tx_error", 32'(tx_error), 32'd0);
      resetn = 1'b1;
      repeat (5) @(negedge clock);
      chk("idle_clk_oe", 32'(clk_oe), 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Device never clocks: abort exactly TIMEOUT cycles after the request
      wait_ready(ok);
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      wait_req(ok);
      chk("to_handshake", 32'(ok), 32'd1);
      n = 0;
      while (!tx_error && n < TIMEOUT + 100) begin
         @(negedge clock);
         n++;
      end
      chk("to_cycles", 32'(n), 32'(TIMEOUT));
      chk("to_clk_oe", 32'(clk_oe), 32'd0);
      chk("to_dat_oe", 32'(dat_oe), 32'd0);
      @(negedge clock);
      chk("to_ready_next", 32'(tx_ready), 32'd1);
      chk("to_err_pulses", 32'(err_cnt - e0), 32'd1);
      chk("to_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Reset asserted at the fifth device fall releases both lines at once
      wait_ready(ok);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      wait_req(ok);
      chk("rs_handshake", 32'(ok), 32'd1);
      repeat (5) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clock);
      end
      chk("rs_pre_dat_oe", 32'(dat_oe), 32'd1);
      dev_clk = 1'b0;
      resetn  = 1'b0;
      #1;
      chk("rs_async_clk_oe", 32'(clk_oe), 32'd0);
      chk("rs_async_dat_oe", 32'(dat_oe), 32'd0);
      chk("rs_async_ready", 32'(tx_ready), 32'd1);
      chk("rs_async_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      dev_clk = 1'b1;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("rs_ready_after", 32'(tx_ready), 32'd1);
      run_vec('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0}, 6);

      // tx_valid held through a transfer with new data: picked up only after done
      wait_ready(ok);
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_data = 8'hAA;
      dev_frame(1'b1, 1'b0, bits, ok);
      chk("hold_handshake1", 32'(ok), 32'd1);
      chk("hold_frame1", 32'(bits), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
      dev_frame(1'b1, 1'b1, bits, ok);
      chk("hold_handshake2", 32'(ok), 32'd1);
      chk("hold_frame2", 32'(bits), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
      wait_ready(ok);
      repeat (50) @(negedge clock);
      chk("hold_done_pulses", 32'(done_cnt - d0), 32'd2);
      chk("hold_err_pulses", 32'(err_cnt - e0), 32'd0);
      chk("hold_no_third", 32'(clk_oe), 32'd0);
      chk("hold_ready", 32'(tx_ready), 32'd1);

      chk("busy_inverse_ready", 32'(busy_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
